// File: rtl/wav_dfi_upd_arb.sv
// DFI update / low-power arbiter: arbitrates PHY update, PHY master, controller
// update and low-power requests onto the DFI sideband and blocks MC traffic meanwhile.
module wav_dfi_upd_arb #(
   parameter int unsigned TLP_RESP     = 8,
   parameter int unsigned TCTRLUPD_MIN = 2,
   parameter int unsigned TCTRLUPD_MAX = 16,
   parameter int unsigned TPHYUPD_RESP = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       init_start,
   input  logic       mc_idle,
   input  logic       mc_ctrlupd_req,
   input  logic       mc_lp_req,
   input  logic [5:0] mc_lp_wakeup,
   input  logic       phyupd_req,
   input  logic [1:0] phyupd_type,
   input  logic       phymstr_req,
   input  logic       ctrlupd_ack,
   input  logic       lp_ctrl_ack,
   output logic       ctrlupd_req,
   output logic       phyupd_ack,
   output logic       phymstr_ack,
   output logic       lp_ctrl_req,
   output logic [5:0] lp_ctrl_wakeup,
   output logic       cmd_block,
   output logic       lp_denied,
   output logic [2:0] err,
   output logic [2:0] arb_state
);

   localparam int unsigned CW = $clog2(TCTRLUPD_MAX + 1);
   localparam int unsigned LW = $clog2(TLP_RESP + 1);
   localparam int unsigned PW = $clog2(TPHYUPD_RESP + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRAIN   = 3'd1,
      PHYUPD  = 3'd2,
      PHYMSTR = 3'd3,
      CTRLUPD = 3'd4,
      LP_REQ  = 3'd5,
      LP_ACT  = 3'd6,
      LP_EXIT = 3'd7
   } state_t;

   state_t        state;
   logic          winner_mstr;
   logic          ctrl_pend;
   logic          lp_ack_q;
   logic [CW-1:0] ctrl_cnt;
   logic [LW-1:0] lp_cnt;
   logic [PW-1:0] phy_wait;

   logic ctrl_go;
   logic phy_waiting;
   logic winner_req;
   logic unused_type;

   // The update type carries no arbitration meaning; every type is handled alike.
   assign unused_type = ^phyupd_type;

   assign ctrl_go = (state == IDLE) && !init_start && !phyupd_req && !phymstr_req &&
                    ctrl_pend && mc_idle;
   assign phy_waiting = (phyupd_req && !phyupd_ack) || (phymstr_req && !phymstr_ack);
   assign winner_req  = winner_mstr ? phymstr_req : phyupd_req;
   assign arb_state   = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         winner_mstr    <= 1'b0;
         ctrl_pend      <= 1'b0;
         lp_ack_q       <= 1'b0;
         ctrl_cnt       <= '0;
         lp_cnt         <= '0;
         phy_wait       <= '0;
         ctrlupd_req    <= 1'b0;
         phyupd_ack     <= 1'b0;
         phymstr_ack    <= 1'b0;
         lp_ctrl_req    <= 1'b0;
         lp_ctrl_wakeup <= '0;
         cmd_block      <= 1'b0;
         lp_denied      <= 1'b0;
         err            <= '0;
      end else begin
         lp_denied <= 1'b0;
         lp_ack_q  <= lp_ctrl_ack;

         // New pulses merge into the pending flag; a pulse on the entry cycle re-arms it.
         if (mc_ctrlupd_req)
            ctrl_pend <= 1'b1;
         else if (ctrl_go)
            ctrl_pend <= 1'b0;

         // Response timer for PHY-initiated requests, saturating at the limit.
         if (!phy_waiting)
            phy_wait <= '0;
         else if (phy_wait == PW'(TPHYUPD_RESP))
            err[0] <= 1'b1;
         else
            phy_wait <= phy_wait + PW'(1);

         if (lp_ack_q && !lp_ctrl_ack && lp_ctrl_req)
            err[2] <= 1'b1;

         case (state)
            IDLE: begin
               cmd_block <= 1'b0;
               if (!init_start) begin
                  if (phyupd_req) begin
                     winner_mstr <= 1'b0;
                     cmd_block   <= 1'b1;
                     state       <= DRAIN;
                  end else if (phymstr_req) begin
                     winner_mstr <= 1'b1;
                     cmd_block   <= 1'b1;
                     state       <= DRAIN;
                  end else if (ctrl_pend) begin
                     cmd_block <= 1'b1;
                     if (ctrl_go) begin
                        ctrlupd_req <= 1'b1;
                        ctrl_cnt    <= CW'(1);
                        state       <= CTRLUPD;
                     end
                  end else if (mc_lp_req) begin
                     lp_ctrl_req    <= 1'b1;
                     lp_ctrl_wakeup <= mc_lp_wakeup;
                     lp_cnt         <= LW'(1);
                     cmd_block      <= 1'b1;
                     state          <= LP_REQ;
                  end
               end
            end

            DRAIN: begin
               if (init_start || !winner_req) begin
                  cmd_block <= 1'b0;
                  state     <= IDLE;
               end else if (mc_idle) begin
                  if (winner_mstr) begin
                     phymstr_ack <= 1'b1;
                     state       <= PHYMSTR;
                  end else begin
                     phyupd_ack <= 1'b1;
                     state      <= PHYUPD;
                  end
               end
            end

            PHYUPD: begin
               if (!phyupd_req || init_start) begin
                  phyupd_ack <= 1'b0;
                  cmd_block  <= 1'b0;
                  state      <= IDLE;
               end
            end

            PHYMSTR: begin
               if (!phymstr_req || init_start) begin
                  phymstr_ack <= 1'b0;
                  cmd_block   <= 1'b0;
                  state       <= IDLE;
               end
            end

            CTRLUPD: begin
               if ((ctrl_cnt >= CW'(TCTRLUPD_MIN) && !ctrlupd_ack) ||
                   ctrl_cnt == CW'(TCTRLUPD_MAX)) begin
                  if (ctrlupd_ack && ctrl_cnt == CW'(TCTRLUPD_MAX))
                     err[1] <= 1'b1;
                  ctrlupd_req <= 1'b0;
                  cmd_block   <= 1'b0;
                  state       <= IDLE;
               end else begin
                  ctrl_cnt <= ctrl_cnt + CW'(1);
               end
            end

            LP_REQ: begin
               if (!mc_lp_req) begin
                  lp_ctrl_req <= 1'b0;
                  if (lp_ctrl_ack) begin
                     state <= LP_EXIT;
                  end else begin
                     cmd_block <= 1'b0;
                     state     <= IDLE;
                  end
               end else if (lp_ctrl_ack) begin
                  state <= LP_ACT;
               end else if (lp_cnt == LW'(TLP_RESP)) begin
                  lp_ctrl_req <= 1'b0;
                  lp_denied   <= 1'b1;
                  cmd_block   <= 1'b0;
                  state       <= IDLE;
               end else begin
                  lp_cnt <= lp_cnt + LW'(1);
               end
            end

            LP_ACT: begin
               if (!mc_lp_req) begin
                  lp_ctrl_req <= 1'b0;
                  state       <= LP_EXIT;
               end
            end

            LP_EXIT: begin
               if (!lp_ctrl_ack) begin
                  cmd_block <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wav_dfi_upd_arb.sv
// Scoreboard bench for wav_dfi_upd_arb: expected output-change events are queued by
// the stimulus thread and matched cycle-accurately by an independent monitor.
module tb_wav_dfi_upd_arb;

   logic       clock = 1'b0;
   logic       reset;
   logic       init_start, mc_idle, mc_ctrlupd_req, mc_lp_req;
   logic [5:0] mc_lp_wakeup;
   logic       phyupd_req, phymstr_req, ctrlupd_ack, lp_ctrl_ack;
   logic [1:0] phyupd_type;
   logic       ctrlupd_req, phyupd_ack, phymstr_ack, lp_ctrl_req, cmd_block, lp_denied;
   logic [5:0] lp_ctrl_wakeup;
   logic [2:0] err, arb_state;

   wav_dfi_upd_arb dut (
      .clock          (clock),
      .reset          (reset),
      .init_start     (init_start),
      .mc_idle        (mc_idle),
      .mc_ctrlupd_req (mc_ctrlupd_req),
      .mc_lp_req      (mc_lp_req),
      .mc_lp_wakeup   (mc_lp_wakeup),
      .phyupd_req     (phyupd_req),
      .phyupd_type    (phyupd_type),
      .phymstr_req    (phymstr_req),
      .ctrlupd_ack    (ctrlupd_ack),
      .lp_ctrl_ack    (lp_ctrl_ack),
      .ctrlupd_req    (ctrlupd_req),
      .phyupd_ack     (phyupd_ack),
      .phymstr_ack    (phymstr_ack),
      .lp_ctrl_req    (lp_ctrl_req),
      .lp_ctrl_wakeup (lp_ctrl_wakeup),
      .cmd_block      (cmd_block),
      .lp_denied      (lp_denied),
      .err            (err),
      .arb_state      (arb_state)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [14:0] val;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   logic [14:0] prev_obs;
   logic [14:0] obs;

   // Observed vector: {cmd_block, phyupd_ack, phymstr_ack, ctrlupd_req, lp_ctrl_req, lp_denied, wakeup, err}
   assign obs = {cmd_block, phyupd_ack, phymstr_ack, ctrlupd_req, lp_ctrl_req, lp_denied,
                 lp_ctrl_wakeup, err};

   function automatic logic [14:0] ov(input logic [5:0] f, input logic [5:0] wk, input logic [2:0] er);
      return {f, wk, er};
   endfunction

   task automatic ex(input int c, input logic [14:0] v);
      exp_t e;
      e.cyc = c;
      e.val = v;
      sbq.push_back(e);
   endtask

   task automatic go(input int c);
      while (cyc < c) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
      end
   endtask

   task automatic clear_inputs();
      init_start     = 1'b0;
      mc_idle        = 1'b1;
      mc_ctrlupd_req = 1'b0;
      mc_lp_req      = 1'b0;
      mc_lp_wakeup   = 6'h00;
      phyupd_req     = 1'b0;
      phyupd_type    = 2'b01;
      phymstr_req    = 1'b0;
      ctrlupd_ack    = 1'b0;
      lp_ctrl_ack    = 1'b0;
   endtask

   task automatic do_reset(input bit expect_change);
      int r;
      r = cyc;
      reset = 1'b1;
      clear_inputs();
      if (expect_change) ex(r + 1, 15'h0000);
      go(r + 1);
      reset = 1'b0;
      chk("reset_arb_state", 32'(arb_state), 32'd0);
      go(r + 3);
   endtask

   // Monitor: every change of the observed vector must match the next queued event.
   always @(negedge clock) begin
      if (mon_en) begin
         if (obs !== prev_obs) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change cyc=%0d actual=%h", cyc, obs);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               if (e.cyc != cyc || e.val !== obs) begin
                  errors++;
                  $display("FAIL sb_event actual cyc=%0d val=%h required cyc=%0d val=%h",
                           cyc, obs, e.cyc, e.val);
               end
            end
            prev_obs = obs;
         end
         if (phyupd_ack || phymstr_ack) begin
            checks++;
            if ((phyupd_ack && phymstr_ack) || ctrlupd_req || lp_ctrl_req || init_start) begin
               errors++;
               $display("FAIL ack_exclusive cyc=%0d actual pu=%b pm=%b cu=%b lp=%b init=%b required lone ack",
                        cyc, phyupd_ack, phymstr_ack, ctrlupd_req, lp_ctrl_req, init_start);
            end
         end
      end
   end

   initial begin
      int b;
      reset = 1'b1;
      clear_inputs();
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("reset_arb_state", 32'(arb_state), 32'd0);
      chk("reset_outputs", 32'(obs), 32'd0);
      prev_obs = obs;
      mon_en   = 1'b1;
      go(cyc + 2);

      // PHY update basic timing
      b = cyc;
      phyupd_req = 1'b1;
      ex(b + 1, ov(6'b100000, 6'h00, 3'b000));
      ex(b + 2, ov(6'b110000, 6'h00, 3'b000));
      ex(b + 11, 15'h0000);
      go(b + 2);
      chk("phyupd_state", 32'(arb_state), 32'd2);
      go(b + 10);
      phyupd_req = 1'b0;
      go(b + 11);
      chk("phyupd_return_idle", 32'(arb_state), 32'd0);
      go(b + 14);

      // ctrlupd with ack low: minimum high time
      b = cyc;
      mc_ctrlupd_req = 1'b1;
      ex(b + 2, ov(6'b100100, 6'h00, 3'b000));
      ex(b + 4, 15'h0000);
      go(b + 1);
      mc_ctrlupd_req = 1'b0;
      go(b + 7);

      // ctrlupd waits for mc_idle; back-to-back pulses merge into one update
      b = cyc;
      mc_idle = 1'b0;
      mc_ctrlupd_req = 1'b1;
      ex(b + 2, ov(6'b100000, 6'h00, 3'b000));
      ex(b + 4, ov(6'b100100, 6'h00, 3'b000));
      ex(b + 6, 15'h0000);
      go(b + 2);
      mc_ctrlupd_req = 1'b0;
      chk("ctrl_blocked_idle_state", 32'(arb_state), 32'd0);
      go(b + 3);
      mc_idle = 1'b1;
      go(b + 4);
      chk("ctrlupd_state", 32'(arb_state), 32'd4);
      go(b + 10);

      // ctrlupd with ack held high: maximum high time and err[1]
      b = cyc;
      ctrlupd_ack = 1'b1;
      mc_ctrlupd_req = 1'b1;
      ex(b + 2, ov(6'b100100, 6'h00, 3'b000));
      ex(b + 18, ov(6'b000000, 6'h00, 3'b010));
      go(b + 1);
      mc_ctrlupd_req = 1'b0;
      go(b + 18);
      ctrlupd_ack = 1'b0;
      go(b + 20);
      do_reset(1'b1);

      // LP request with no ack: timeout and denial pulse
      b = cyc;
      mc_lp_req = 1'b1;
      mc_lp_wakeup = 6'h0A;
      ex(b + 1, ov(6'b100010, 6'h0A, 3'b000));
      ex(b + 9, ov(6'b000001, 6'h0A, 3'b000));
      ex(b + 10, ov(6'b000000, 6'h0A, 3'b000));
      go(b + 9);
      mc_lp_req = 1'b0;
      go(b + 12);

      // LP request acked, active, exit
      b = cyc;
      mc_lp_req = 1'b1;
      mc_lp_wakeup = 6'h15;
      ex(b + 1, ov(6'b100010, 6'h15, 3'b000));
      ex(b + 7, ov(6'b100000, 6'h15, 3'b000));
      ex(b + 10, ov(6'b000000, 6'h15, 3'b000));
      go(b + 3);
      lp_ctrl_ack = 1'b1;
      go(b + 4);
      chk("lp_act_state", 32'(arb_state), 32'd6);
      go(b + 6);
      mc_lp_req = 1'b0;
      go(b + 7);
      chk("lp_exit_state", 32'(arb_state), 32'd7);
      go(b + 9);
      lp_ctrl_ack = 1'b0;
      go(b + 12);

      // lp_ctrl_ack falls while lp_ctrl_req is high: err[2]
      b = cyc;
      mc_lp_req = 1'b1;
      mc_lp_wakeup = 6'h03;
      ex(b + 1, ov(6'b100010, 6'h03, 3'b000));
      ex(b + 5, ov(6'b100010, 6'h03, 3'b100));
      ex(b + 7, ov(6'b100000, 6'h03, 3'b100));
      ex(b + 8, ov(6'b000000, 6'h03, 3'b100));
      go(b + 2);
      lp_ctrl_ack = 1'b1;
      go(b + 4);
      lp_ctrl_ack = 1'b0;
      go(b + 6);
      mc_lp_req = 1'b0;
      go(b + 10);
      do_reset(1'b1);

      // Simultaneous phyupd, phymstr and ctrlupd: fixed priority, serialised
      b = cyc;
      phyupd_req = 1'b1;
      phymstr_req = 1'b1;
      mc_ctrlupd_req = 1'b1;
      ex(b + 1, ov(6'b100000, 6'h00, 3'b000));
      ex(b + 2, ov(6'b110000, 6'h00, 3'b000));
      ex(b + 6, 15'h0000);
      ex(b + 7, ov(6'b100000, 6'h00, 3'b000));
      ex(b + 8, ov(6'b101000, 6'h00, 3'b000));
      ex(b + 11, 15'h0000);
      ex(b + 12, ov(6'b100100, 6'h00, 3'b000));
      ex(b + 14, 15'h0000);
      go(b + 1);
      mc_ctrlupd_req = 1'b0;
      go(b + 5);
      phyupd_req = 1'b0;
      go(b + 8);
      chk("phymstr_state", 32'(arb_state), 32'd3);
      go(b + 10);
      phymstr_req = 1'b0;
      go(b + 16);

      // init_start holds everything off; phyupd then ctrlupd follow its release
      b = cyc;
      init_start = 1'b1;
      phyupd_req = 1'b1;
      phymstr_req = 1'b1;
      mc_lp_req = 1'b1;
      mc_lp_wakeup = 6'h2A;
      mc_ctrlupd_req = 1'b1;
      ex(b + 11, ov(6'b100000, 6'h00, 3'b000));
      ex(b + 12, ov(6'b110000, 6'h00, 3'b000));
      ex(b + 15, 15'h0000);
      ex(b + 16, ov(6'b100100, 6'h00, 3'b000));
      ex(b + 18, 15'h0000);
      go(b + 1);
      mc_ctrlupd_req = 1'b0;
      go(b + 9);
      chk("init_hold_state", 32'(arb_state), 32'd0);
      go(b + 10);
      init_start = 1'b0;
      phymstr_req = 1'b0;
      mc_lp_req = 1'b0;
      go(b + 14);
      phyupd_req = 1'b0;
      go(b + 20);

      // PHY response timeout while MC stays busy: err[0], FSM keeps waiting
      b = cyc;
      phyupd_req = 1'b1;
      mc_idle = 1'b0;
      ex(b + 1, ov(6'b100000, 6'h00, 3'b000));
      ex(b + 17, ov(6'b100000, 6'h00, 3'b001));
      ex(b + 19, ov(6'b110000, 6'h00, 3'b001));
      ex(b + 21, ov(6'b000000, 6'h00, 3'b001));
      go(b + 17);
      chk("drain_wait_state", 32'(arb_state), 32'd1);
      go(b + 18);
      mc_idle = 1'b1;
      go(b + 20);
      phyupd_req = 1'b0;
      go(b + 23);
      do_reset(1'b1);

      // Reset during PHYUPD with ack high aborts immediately
      b = cyc;
      phyupd_req = 1'b1;
      ex(b + 1, ov(6'b100000, 6'h00, 3'b000));
      ex(b + 2, ov(6'b110000, 6'h00, 3'b000));
      ex(b + 5, 15'h0000);
      go(b + 4);
      reset = 1'b1;
      go(b + 5);
      chk("reset_mid_phyupd_ack", 32'(phyupd_ack), 32'd0);
      chk("reset_mid_phyupd_state", 32'(arb_state), 32'd0);
      reset = 1'b0;
      phyupd_req = 1'b0;
      go(b + 9);

      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_drain actual=%0d pending events required=0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wav_dfi_upd_arb.md
WAV_DFI_UPD_ARB -- requirements
Module: wav_dfi_upd_arb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- TLP_RESP, 8, cycles allowed for lp_ctrl_ack after lp_ctrl_req rises.
- TCTRLUPD_MIN, 2, minimum ctrlupd_req high time.
- TCTRLUPD_MAX, 16, maximum ctrlupd_req high time.
- TPHYUPD_RESP, 16, cycles allowed from phyupd_req/phymstr_req rise to ack.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- init_start  in  1  DFI init in progress; blocks all grants.
- mc_idle  in  1  MC command/data path is idle.
- mc_ctrlupd_req  in  1  one-cycle pulse; MC requests a ctrl update.
- mc_lp_req  in  1  level; MC requests low-power entry.
- mc_lp_wakeup  in  6  wakeup code for the LP request.
- phyupd_req  in  1  DFI PHY update request.
- phyupd_type  in  2  DFI PHY update type.
- phymstr_req  in  1  DFI PHY master request.
- ctrlupd_ack  in  1  DFI ctrl update ack.
- lp_ctrl_ack  in  1  DFI LP ctrl ack.
- ctrlupd_req  out  1  DFI ctrl update request.
- phyupd_ack  out  1  DFI PHY update ack.
- phymstr_ack  out  1  DFI PHY master ack.
- lp_ctrl_req  out  1  DFI LP ctrl request.
- lp_ctrl_wakeup  out  6  DFI LP wakeup code.
- cmd_block  out  1  MC must stop issuing commands and drive address to 0.
- lp_denied  out  1  one-cycle pulse; LP request timed out.
- err  out  3  sticky error flags: [0] phyupd/phymstr response timeout, [1] ctrlupd_ack still high at TCTRLUPD_MAX, [2] lp_ctrl_ack fell before lp_ctrl_req.
- arb_state  out  3  current FSM state encoding.

Function
REQ-003 The FSM SHALL have states IDLE=0, DRAIN=1, PHYUPD=2, PHYMSTR=3, CTRLUPD=4, LP_REQ=5, LP_ACT=6, LP_EXIT=7. All DFI outputs SHALL be registered.
REQ-004 A mc_ctrlupd_req pulse SHALL set a pending flag, cleared when CTRLUPD is entered. Pulses that arrive while the flag is already set SHALL merge into it.
REQ-005 In IDLE with init_start=0, the FSM SHALL service requests with fixed priority phyupd_req > phymstr_req > ctrlupd pending > mc_lp_req. While init_start=1 it SHALL stay in IDLE and issue no req or ack.
REQ-006 A phyupd or phymstr win SHALL move IDLE->DRAIN with the winner latched. cmd_block=1 in DRAIN. When mc_idle=1, DRAIN SHALL go to PHYUPD or PHYMSTR and the matching ack SHALL rise on the next cycle.
REQ-007 If the ack has not risen within TPHYUPD_RESP cycles of the request rising, err[0] SHALL set. The FSM SHALL keep waiting.
REQ-008 In PHYUPD, phyupd_ack SHALL stay high while phyupd_req=1. The first cycle phyupd_req is sampled low, ack SHALL drop on the next edge and the FSM SHALL return to IDLE. PHYMSTR SHALL behave the same with phymstr_req/phymstr_ack.
REQ-009 phyupd_ack and phymstr_ack SHALL never both be high. An ack SHALL never be high while ctrlupd_req, lp_ctrl_req or init_start is high.
REQ-010 CTRLUPD SHALL be entered only when mc_idle=1; otherwise the FSM SHALL stay in IDLE with cmd_block=1. In CTRLUPD, ctrlupd_req=1 and cmd_block=1, and a cycle counter starts at 1.
REQ-011 ctrlupd_req SHALL drop when (count >= TCTRLUPD_MIN and ctrlupd_ack=0) or count == TCTRLUPD_MAX. The FSM SHALL then return to IDLE.
REQ-012 If ctrlupd_ack=1 at count == TCTRLUPD_MAX, err[1] SHALL set.
REQ-013 On entry to LP_REQ, lp_ctrl_req=1 and lp_ctrl_wakeup SHALL take mc_lp_wakeup captured at entry. cmd_block SHALL be 1 in LP_REQ, LP_ACT and LP_EXIT.
REQ-014 In LP_REQ, the FSM SHALL go to LP_ACT when lp_ctrl_ack=1 within TLP_RESP cycles. After TLP_RESP cycles with no ack, lp_ctrl_req SHALL drop, lp_denied SHALL pulse, and the FSM SHALL return to IDLE.
REQ-015 In LP_REQ, mc_lp_req=0 SHALL drop lp_ctrl_req. The FSM SHALL then go to IDLE if no ack has been seen, else to LP_EXIT.
REQ-016 In LP_ACT, lp_ctrl_req SHALL stay high while mc_lp_req=1. mc_lp_req=0 SHALL drop lp_ctrl_req and move to LP_EXIT.
REQ-017 LP_EXIT SHALL go to IDLE when lp_ctrl_ack=0.
REQ-018 lp_ctrl_ack falling while lp_ctrl_req=1 SHALL set err[2].
REQ-019 phyupd_req and phymstr_req arriving in any LP state SHALL be serviced only after IDLE is reached.
REQ-020 arb_state SHALL equal the state encoding every cycle.

Reset
REQ-021 With reset=1 at a clock edge, next cycle: state IDLE, all req/ack outputs 0, lp_ctrl_wakeup 0, cmd_block 0, lp_denied 0, err 0, ctrlupd pending flag and all counters cleared.
REQ-022 Reset mid-transaction SHALL abort the transaction with no further handshake activity.

Verification
REQ-023 phyupd_req rises at cycle 0 with mc_idle=1 -> cmd_block=1 at cycle 1, phyupd_ack=1 at cycle 2. Req falls at cycle 10 -> ack=0 at cycle 11, IDLE.
REQ-024 mc_ctrlupd_req pulse, ctrlupd_ack held 0 -> ctrlupd_req high exactly 2 cycles. Ack held 1 throughout -> req high 16 cycles and err[1]=1.
REQ-025 mc_lp_req=1, wakeup=6'h0A, no ack -> lp_ctrl_req high 8 cycles with wakeup 0x0A, then lp_denied pulse and IDLE.
REQ-026 phyupd_req, phymstr_req and mc_ctrlupd_req all arrive the same cycle -> phyupd served first, then phymstr, then ctrlupd, with no overlapping acks.
REQ-027 init_start=1 with all requests active -> no req or ack output for as long as init_start=1. init_start falls -> phyupd_ack follows per REQ-023 timing.
REQ-028 reset asserted during PHYUPD with ack high -> phyupd_ack=0 and arb_state=0 on the next cycle.
